// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath: sequences fetch/decode/exec/mem/wb,
// handles memory ready handshake, stalls, illegal-opcode traps and memory wait timeouts.
module mc_control_fsm #(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                sign_or_zero,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [2:0]          state_o
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSlti = 3'd1;
  localparam logic [2:0] OpJ    = 3'd2;
  localparam logic [2:0] OpJal  = 3'd3;
  localparam logic [2:0] OpLw   = 3'd4;
  localparam logic [2:0] OpSw   = 3'd5;
  localparam logic [2:0] OpBeq  = 3'd6;
  localparam logic [2:0] OpAddi = 3'd7;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic       legal;
  logic [2:0] op3;
  logic       mem_wait;
  logic       abort;

  // Any opcode bit above [2:0] marks the instruction illegal.
  assign legal = (opcode >> 3) == '0;
  assign op3   = opcode[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_op       = 2'b00;
    alu_src      = 1'b0;
    sign_or_zero = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    mem_wait     = 1'b0;
    abort        = 1'b0;

    if (state_q != StFetch && legal) begin
      unique case (op3)
        OpAdd:  begin reg_dst = 2'b01; end
        OpSlti: begin alu_op = 2'b10; alu_src = 1'b1; sign_or_zero = 1'b0; end
        OpJ:    begin end
        OpJal:  begin reg_dst = 2'b10; mem_to_reg = 2'b10; end
        OpLw:   begin mem_to_reg = 2'b01; alu_op = 2'b11; alu_src = 1'b1; end
        OpSw:   begin alu_op = 2'b11; alu_src = 1'b1; end
        OpBeq:  begin alu_op = 2'b01; end
        OpAddi: begin alu_op = 2'b11; alu_src = 1'b1; end
        default: begin end
      endcase
    end

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        mem_wait = ~mem_ready;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (!legal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (op3 == OpJ || op3 == OpJal) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = (op3 == OpJal);
          instr_done = 1'b1;
          state_d    = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op3 == OpBeq) begin
          pc_write   = zero;
          pc_src     = 2'b01;
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (op3 == OpLw || op3 == OpSw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_read  = (op3 == OpLw);
        mem_write = (op3 == OpSw);
        mem_wait  = ~mem_ready;
        if (mem_ready) begin
          if (op3 == OpLw) begin
            state_d = StWb;
          end else begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_wait) begin
      if (cnt_q == CntMax) begin
        abort = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Timeout abort drops the whole transaction and restarts from fetch.
    if (abort && !stall) begin
      state_d    = StFetch;
      cnt_d      = '0;
      timeout_d  = 1'b1;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end

    if (stall) begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end

    if (reset) begin
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      reg_dst      = 2'b00;
      mem_to_reg   = 2'b00;
      alu_op       = 2'b00;
      alu_src      = 1'b0;
      sign_or_zero = 1'b1;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      instr_done   = 1'b0;
      illegal_op   = 1'b0;
    end
  end

  assign mem_timeout = timeout_q;
  assign state_o     = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios then random stimulus, every cycle compared
// against a route-table model of instruction phases.
module tb_mc_control_fsm;
  localparam int unsigned OW = 4;
  localparam int unsigned TO = 4;

  localparam logic [OW-1:0] OP_ADD  = 4'd0;
  localparam logic [OW-1:0] OP_J    = 4'd2;
  localparam logic [OW-1:0] OP_LW   = 4'd4;
  localparam logic [OW-1:0] OP_SW   = 4'd5;
  localparam logic [OW-1:0] OP_BEQ  = 4'd6;
  localparam logic [OW-1:0] OP_ILL  = 4'b1000;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready, stall;
  logic [OW-1:0] opcode;
  logic          pc_write, ir_write, alu_src, sign_or_zero, mem_read, mem_write;
  logic          reg_write, instr_done, illegal_op, mem_timeout;
  logic [1:0]    pc_src, reg_dst, mem_to_reg, alu_op;
  logic [2:0]    state_o;

  int checks   = 0;
  int failures = 0;

  // Model: each instruction class walks a fixed list of phases (0 fetch .. 4 writeback).
  int route [9][5];
  int rlen  [9];
  int m_step = 0;
  int m_wait = 0;
  bit m_to   = 1'b0;

  mc_control_fsm #(.OPCODE_W(OW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .stall(stall), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src),
    .sign_or_zero(sign_or_zero), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fields_of(input int cls);
    // {reg_dst, mem_to_reg, alu_op, alu_src, sign_or_zero}
    case (cls)
      0:       return 8'b01_00_00_0_1;
      1:       return 8'b00_00_10_1_0;
      3:       return 8'b10_10_00_0_1;
      4:       return 8'b00_01_11_1_1;
      5, 7:    return 8'b00_00_11_1_1;
      6:       return 8'b00_00_01_0_1;
      default: return 8'b00_00_00_0_1;
    endcase
  endfunction

  task automatic run_cycle(input bit r, input bit s, input bit rdy, input bit z,
                           input logic [OW-1:0] op, input string tag);
    int         cls, ph;
    bit         is_mem, last, adv, abrt;
    bit         pw, iw, rw, mr, mw, done, ill;
    logic [1:0] ps;
    logic [7:0] f;
    logic [2:0] st;
    logic [20:0] exp_v, got_v;
    @(negedge clk);
    reset = r; stall = s; mem_ready = rdy; zero = z; opcode = op;
    #1;
    cls  = (op < 8) ? int'(op) : 8;
    ph   = route[cls][m_step];
    f    = (ph != 0) ? fields_of(cls) : 8'b00_00_00_0_1;
    is_mem = (ph == 0) || (ph == 3);
    last = (m_step == rlen[cls] - 1);
    adv  = is_mem ? rdy : 1'b1;
    abrt = is_mem && !rdy && !s && (m_wait == TO - 1);
    {pw, iw, rw, mr, mw, done, ill} = '0;
    ps = 2'b00;
    case (ph)
      0: begin mr = 1'b1; iw = rdy; pw = rdy; end
      1: begin
        if (cls == 8) ill = 1'b1;
        else if (cls == 2 || cls == 3) begin pw = 1'b1; ps = 2'b10; rw = (cls == 3); end
      end
      2: if (cls == 6) begin pw = z; ps = 2'b01; end
      3: begin mr = (cls == 4); mw = (cls == 5); end
      default: rw = 1'b1;
    endcase
    done = last && adv;
    if (abrt || s) {pw, iw, rw, mr, mw, done, ill} = '0;
    st = 3'(ph);
    if (r) begin
      {pw, iw, rw, mr, mw, done, ill} = '0;
      ps = 2'b00; f = 8'b00_00_00_0_1; st = 3'd0;
    end
    exp_v = {pw, ps, iw, f, mr, mw, rw, done, ill, m_to, st};
    got_v = {pc_write, pc_src, ir_write, reg_dst, mem_to_reg, alu_op, alu_src, sign_or_zero,
             mem_read, mem_write, reg_write, instr_done, illegal_op, mem_timeout, state_o};
    check_eq(tag, 32'(got_v), 32'(exp_v));
    if (r) begin
      m_step = 0; m_wait = 0; m_to = 1'b0;
    end else if (s) begin
    end else if (abrt) begin
      m_step = 0; m_wait = 0; m_to = 1'b1;
    end else if (adv) begin
      m_step = last ? 0 : m_step + 1; m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    logic [OW-1:0] rop;
    for (int c = 0; c < 9; c++) begin
      route[c] = '{0, 1, 2, 4, 0};
      rlen[c]  = 4;
    end
    route[2] = '{0, 1, 0, 0, 0}; rlen[2] = 2;
    route[3] = '{0, 1, 0, 0, 0}; rlen[3] = 2;
    route[4] = '{0, 1, 2, 3, 4}; rlen[4] = 5;
    route[5] = '{0, 1, 2, 3, 0}; rlen[5] = 4;
    route[6] = '{0, 1, 2, 0, 0}; rlen[6] = 3;
    route[8] = '{0, 1, 0, 0, 0}; rlen[8] = 2;

    reset = 1'b1; stall = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    run_cycle(1, 0, 0, 0, OP_ADD, "reset_state");

    // sw aborted by reset while waiting in MEM
    run_cycle(0, 0, 1, 0, OP_SW, "t1_fetch");
    run_cycle(0, 0, 1, 0, OP_SW, "t1_decode");
    run_cycle(0, 0, 1, 0, OP_SW, "t1_exec");
    run_cycle(0, 0, 0, 0, OP_SW, "t1_mem_wait");
    run_cycle(1, 0, 0, 0, OP_SW, "t1_reset0");
    run_cycle(1, 0, 0, 0, OP_SW, "t1_reset1");
    run_cycle(0, 0, 0, 0, OP_ADD, "t1_after");
    check_eq("t1_state", 32'(state_o), 32'd0);
    check_eq("t1_timeout", 32'(mem_timeout), 32'd0);
    run_cycle(1, 0, 0, 0, OP_ADD, "t1_clr");

    // every legal opcode with memory always ready
    for (int o = 0; o < 8; o++)
      for (int k = 0; k < rlen[o]; k++) run_cycle(0, 0, 1, 0, 4'(o), "t2_legal");

    // lw with three not-ready cycles in MEM
    for (int k = 0; k < 3; k++) run_cycle(0, 0, 1, 0, OP_LW, "t3_pre");
    for (int k = 0; k < 3; k++) run_cycle(0, 0, 0, 0, OP_LW, "t3_mem_wait");
    run_cycle(0, 0, 1, 0, OP_LW, "t3_mem_done");
    run_cycle(0, 0, 1, 0, OP_LW, "t3_wb");
    check_eq("t3_wb_m2r", 32'(mem_to_reg), 32'd1);

    // beq taken and not taken
    for (int zz = 1; zz >= 0; zz--)
      for (int k = 0; k < 3; k++) run_cycle(0, 0, 1, zz[0], OP_BEQ, "t4_beq");

    // illegal opcode
    run_cycle(0, 0, 1, 0, OP_ILL, "t5_fetch");
    run_cycle(0, 0, 1, 0, OP_ILL, "t5_decode");
    check_eq("t5_illegal", 32'(illegal_op), 32'd1);
    run_cycle(0, 0, 1, 0, OP_J, "t5_next");

    // j completes, then fetch timeout with a stall in the middle of the wait
    run_cycle(0, 0, 1, 0, OP_J, "t6_j");
    run_cycle(0, 0, 0, 0, OP_ADD, "t6_wait0");
    run_cycle(0, 0, 0, 0, OP_ADD, "t6_wait1");
    run_cycle(0, 1, 0, 0, OP_ADD, "t6_stall");
    run_cycle(0, 0, 0, 0, OP_ADD, "t6_wait2");
    run_cycle(0, 0, 0, 0, OP_ADD, "t6_abort");
    check_eq("t6_no_irw", 32'(ir_write), 32'd0);
    for (int k = 0; k < 4; k++) run_cycle(0, 0, 1, 0, OP_ADD, "t6_post");
    check_eq("t6_sticky", 32'(mem_timeout), 32'd1);
    run_cycle(1, 0, 1, 0, OP_ADD, "t6_reset");
    run_cycle(0, 0, 1, 0, OP_ADD, "t6_cleared");
    check_eq("t6_cleared_to", 32'(mem_timeout), 32'd0);

    rop = OP_ADD;
    for (int n = 0; n < 3000; n++) begin
      if (m_step == 0)
        rop = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7))
                                         : 4'($urandom_range(0, 7));
      run_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, rop, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
